// File: rtl/dm_arbiter.sv
// Two-requester arbiter (CPU MEM stage R0, DMA R1) sharing one single-port data memory.
// Build option DM_ARB_ROUND_ROBIN_EN: round-robin contention; otherwise R0 priority with a starvation limit.
module dm_arbiter #(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_adr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_rvalid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_adr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_rvalid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic        dm_we,
    output logic [31:0] dm_adr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    logic        rst_hold_q, rst_hold_d;
    logic        tag_valid_q, tag_valid_d;
    logic        tag_owner_q, tag_owner_d;
    logic        tag_we_q, tag_we_d;
    logic        tag_err_q, tag_err_d;
    logic        blocked, both_req, pick_r1, any_gnt, misaligned;
    logic        win_we;
    logic [31:0] win_adr, win_wdata;
    logic        rsp_live, r0_data_ok, r1_data_ok;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic        rr_ptr_q, rr_ptr_d;
`else
    logic [3:0]  streak_q, streak_d;
`endif

    // Grants are also held off the cycle after reset so reset blanks two full cycles.
    assign blocked  = RST | rst_hold_q;
    assign both_req = r0_req & r1_req;

`ifdef DM_ARB_ROUND_ROBIN_EN
    assign pick_r1 = both_req & rr_ptr_q;
`else
    assign pick_r1 = both_req & (streak_q == 4'(MAX_STREAK));
`endif

    assign r1_gnt  = ~blocked & r1_req & (~r0_req | pick_r1);
    assign r0_gnt  = ~blocked & r0_req & ~pick_r1;
    assign any_gnt = r0_gnt | r1_gnt;

    always_comb begin
        win_we    = r0_we;
        win_adr   = r0_adr;
        win_wdata = r0_wdata;
        if (r1_gnt) begin
            win_we    = r1_we;
            win_adr   = r1_adr;
            win_wdata = r1_wdata;
        end
    end

    // Misaligned accesses are accepted and answered with err but never touch memory.
    assign misaligned = (win_adr[1:0] != 2'b00);
    assign dm_we      = any_gnt & ~misaligned & win_we;
    assign dm_adr     = (any_gnt & ~misaligned) ? win_adr   : 32'd0;
    assign dm_wdata   = (any_gnt & ~misaligned) ? win_wdata : 32'd0;

    always_comb begin
        rst_hold_d  = RST;
        tag_valid_d = any_gnt;
        tag_owner_d = r1_gnt;
        tag_we_d    = win_we;
        tag_err_d   = misaligned;
`ifdef DM_ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
        if (both_req & any_gnt) begin
            rr_ptr_d = r0_gnt;
        end
`else
        streak_d = streak_q;
        if (r1_gnt | ~r1_req) begin
            streak_d = 4'd0;
        end else if (r0_gnt) begin
            streak_d = streak_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        rst_hold_q <= rst_hold_d;
        if (RST) begin
            tag_valid_q <= 1'b0;
            tag_owner_q <= 1'b0;
            tag_we_q    <= 1'b0;
            tag_err_q   <= 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= 1'b0;
`else
            streak_q    <= 4'd0;
`endif
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_owner_q <= tag_owner_d;
            tag_we_q    <= tag_we_d;
            tag_err_q   <= tag_err_d;
`ifdef DM_ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`else
            streak_q    <= streak_d;
`endif
        end
    end

    // A response captured just before reset must not leak out during the reset cycle.
    assign rsp_live   = tag_valid_q & ~RST;
    assign r0_rvalid  = rsp_live & ~tag_owner_q;
    assign r1_rvalid  = rsp_live & tag_owner_q;
    assign r0_err     = r0_rvalid & tag_err_q;
    assign r1_err     = r1_rvalid & tag_err_q;
    assign r0_data_ok = r0_rvalid & ~tag_we_q & ~tag_err_q;
    assign r1_data_ok = r1_rvalid & ~tag_we_q & ~tag_err_q;
    assign r0_rdata   = r0_data_ok ? dm_rdata : 32'd0;
    assign r1_rdata   = r1_data_ok ? dm_rdata : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural registered-read data memory.
// Contention expectations follow DM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_dm_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
    logic [31:0] r0_adr = 0, r0_wdata = 0, r1_adr = 0, r1_wdata = 0;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err, dm_we;
    logic [31:0] r0_rdata, r1_rdata, dm_adr, dm_wdata, dm_rdata;
    logic [31:0] mem [0:255];
    int          errors = 0;
    int          checks = 0;
    logic        exp_r1, prev_r1;

    dm_arbiter #(.MAX_STREAK(4)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .dm_we(dm_we), .dm_adr(dm_adr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    always #5 CLK = ~CLK;

    // Single-port memory: read data returns one cycle later and shows the pre-write value.
    always @(posedge CLK) begin
        if (dm_we) mem[dm_adr[9:2]] <= dm_wdata;
        dm_rdata <= mem[dm_adr[9:2]];
    end

    task automatic applyStimulus(input logic rst,
                                 input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        @(negedge CLK);
        RST = rst;
        r0_req = q0; r0_we = w0; r0_adr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_adr = a1; r1_wdata = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8] = 32'hA5A5_0020;

        applyStimulus(1, 0,0,0,0, 0,0,0,0);
        checkOutput("rst_r0_gnt", r0_gnt, 0);
        checkOutput("rst_r0_rvalid", r0_rvalid, 0);
        checkOutput("rst_dm_adr", dm_adr, 0);
        applyStimulus(1, 0,0,0,0, 0,0,0,0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("post_rst_r1_rvalid", r1_rvalid, 0);

        applyStimulus(0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0);
        checkOutput("st_r0_gnt", r0_gnt, 1);
        checkOutput("st_r1_gnt", r1_gnt, 0);
        checkOutput("st_dm_we", dm_we, 1);
        checkOutput("st_dm_adr", dm_adr, 32'h10);
        checkOutput("st_dm_wdata", dm_wdata, 32'hDEADBEEF);
        applyStimulus(0, 1,0,32'h10,0, 0,0,0,0);
        checkOutput("ld_r0_gnt", r0_gnt, 1);
        checkOutput("ld_dm_we", dm_we, 0);
        checkOutput("st_r0_rvalid", r0_rvalid, 1);
        checkOutput("st_r0_rdata", r0_rdata, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("ld_r0_rvalid", r0_rvalid, 1);
        checkOutput("ld_r0_rdata", r0_rdata, 32'hDEADBEEF);
        checkOutput("idle_dm_adr", dm_adr, 0);
        checkOutput("idle_dm_wdata", dm_wdata, 0);

        applyStimulus(0, 0,0,0,0, 1,0,32'h22,0);
        checkOutput("mis_r1_gnt", r1_gnt, 1);
        checkOutput("mis_dm_we", dm_we, 0);
        checkOutput("mis_dm_adr", dm_adr, 0);
        applyStimulus(0, 1,0,32'h20,0, 0,0,0,0);
        checkOutput("mis_r1_rvalid", r1_rvalid, 1);
        checkOutput("mis_r1_err", r1_err, 1);
        checkOutput("mis_r1_rdata", r1_rdata, 0);
        checkOutput("mis_r0_rvalid", r0_rvalid, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("mem_unchanged", r0_rdata, 32'hA5A5_0020);
        checkOutput("ok_r0_err", r0_err, 0);

        applyStimulus(0, 0,0,0,0, 1,1,32'h40,32'h1234);
        checkOutput("dma_st_gnt", r1_gnt, 1);
        applyStimulus(0, 1,0,32'h40,0, 0,0,0,0);
        checkOutput("dma_st_rvalid", r1_rvalid, 1);
        checkOutput("cpu_ld_gnt", r0_gnt, 1);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("cpu_ld_rdata", r0_rdata, 32'h1234);
        checkOutput("dma_no_rvalid", r1_rvalid, 0);

        applyStimulus(0, 0,0,0,0, 1,0,32'h40,0);
        applyStimulus(0, 0,0,0,0, 1,1,32'h40,32'h5678);
        checkOutput("ldst_r1_gnt", r1_gnt, 1);
        checkOutput("ldst_r1_rdata", r1_rdata, 32'h1234);
        applyStimulus(0, 1,0,32'h40,0, 0,0,0,0);
        checkOutput("ldst_st_rdata", r1_rdata, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("ldst_new_data", r0_rdata, 32'h5678);

        prev_r1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
            exp_r1 = (i % 2 == 1);
`else
            exp_r1 = (i % 5 == 4);
`endif
            applyStimulus(0, 1,0,32'h10,0, 1,0,32'h40,0);
            checkOutput($sformatf("cont%0d_r0_gnt", i), r0_gnt, !exp_r1);
            checkOutput($sformatf("cont%0d_r1_gnt", i), r1_gnt, exp_r1);
            checkOutput($sformatf("cont%0d_dm_adr", i), dm_adr, exp_r1 ? 32'h40 : 32'h10);
            if (i > 0) begin
                checkOutput($sformatf("cont%0d_r1_rvalid", i), r1_rvalid, prev_r1);
                checkOutput($sformatf("cont%0d_r0_rdata", i), r0_rdata, prev_r1 ? 32'h0 : 32'hDEADBEEF);
            end
            prev_r1 = exp_r1;
        end

        applyStimulus(0, 1,0,32'h10,0, 0,0,0,0);
        checkOutput("pre_rst_r0_gnt", r0_gnt, 1);
        applyStimulus(1, 1,0,32'h10,0, 1,0,32'h40,0);
        checkOutput("in_rst_r0_gnt", r0_gnt, 0);
        checkOutput("in_rst_r1_gnt", r1_gnt, 0);
        checkOutput("in_rst_r0_rvalid", r0_rvalid, 0);
        checkOutput("in_rst_r0_rdata", r0_rdata, 0);
        checkOutput("in_rst_dm_adr", dm_adr, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("after_rst_r0_rvalid", r0_rvalid, 0);
        checkOutput("after_rst_r0_rdata", r0_rdata, 0);
        applyStimulus(0, 1,0,32'h10,0, 1,0,32'h40,0);
        checkOutput("first_cont_r0_gnt", r0_gnt, 1);
        checkOutput("first_cont_r1_gnt", r1_gnt, 0);
        applyStimulus(0, 0,0,0,0, 0,0,0,0);
        checkOutput("first_cont_rdata", r0_rdata, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4, meaning: max consecutive R0 grants while R1 waits (fixed-priority mode).
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 r0_req, r1_req  in  1  access request from CPU MEM stage (R0) / DMA port (R1).
REQ-005 rN_we  in  1  1=store, 0=load; rN_adr  in  32  byte address; rN_wdata  in  32  store data.
REQ-006 rN_gnt  out  1  request accepted this cycle (combinational from req and state).
REQ-007 rN_rvalid  out  1  response for rN's accepted access, one cycle after gnt.
REQ-008 rN_rdata  out  32  load data, valid with rN_rvalid; rN_err  out  1  misaligned-access flag, valid with rN_rvalid.
REQ-009 dm_we  out  1, dm_adr  out  32, dm_wdata  out  32  single-port data-memory request (DM samples on CLK edge).
REQ-010 dm_rdata  in  32  DM registered read data, valid one cycle after a load is presented.

Function
REQ-011 At most one of r0_gnt/r1_gnt SHALL be high per cycle; gnt only when matching req high and RST low.
REQ-012 Uncontended request SHALL be granted in the same cycle; throughput one access per cycle, no bubbles.
REQ-013 Granted aligned access SHALL drive dm_adr/dm_wdata/dm_we from the winner in the grant cycle; idle cycles drive dm_we=0, dm_adr=0, dm_wdata=0.
REQ-014 Registered response tag (valid, owner, we, err) SHALL capture each grant; next cycle rOwner_rvalid=1 for loads and stores alike.
REQ-015 rN_rdata SHALL equal dm_rdata for aligned loads, 0 for stores and errored accesses; non-owner rdata=0.
REQ-016 Access with adr[1:0]!=0 SHALL still be granted, SHALL NOT reach DM (dm_we=0, dm_adr=0), and SHALL return rvalid=1, err=1, rdata=0.
REQ-017 Contention, macro absent: R0 wins; 4-bit streak counter increments per R0 grant while r1_req high, clears on any R1 grant or when r1_req low.
REQ-018 When streak counter == MAX_STREAK and both request, R1 SHALL win that cycle (counter then clears).
REQ-019 Requester not granted SHALL hold req/we/adr/wdata stable; arbiter needs no internal request buffering.
REQ-020 Load followed immediately by store from either requester SHALL both complete; returning load data SHALL be unaffected by the store in the next cycle.

Reset
REQ-021 RST high: all gnt, rvalid, err, rdata, dm_* outputs SHALL be 0 in that cycle and the next.
REQ-022 RST SHALL clear response tag, streak counter and RR pointer (pointer = R0 preferred).
REQ-023 Access granted in cycle before RST asserts SHALL have its response dropped (no rvalid after reset).

Configuration
REQ-024 Macro DM_ARB_ROUND_ROBIN_EN defined: contention resolved by 1-bit RR pointer; loser of last contended cycle wins next; pointer toggles only on contended grants; streak counter and MAX_STREAK unused.
REQ-025 Macro undefined: fixed priority with starvation limit per REQ-017/018.

Verification
REQ-026 R0 store adr=0x10 data=0xDEADBEEF, then R0 load 0x10 -> gnt both cycles, load rvalid with rdata=0xDEADBEEF one cycle after its gnt.
REQ-027 Both req continuously, macro absent, MAX_STREAK=4 -> grant pattern R0,R0,R0,R0,R1 repeating.
REQ-028 Both req continuously, DM_ARB_ROUND_ROBIN_EN -> grants alternate R0,R1,R0,R1 starting with R0 after reset.
REQ-029 R1 load adr=0x22 -> r1_gnt=1, dm_we=0, dm_adr=0; next cycle r1_rvalid=1, r1_err=1, r1_rdata=0; memory unchanged.
REQ-030 R0 load granted, RST asserted next cycle -> no r0_rvalid, all outputs 0 for two cycles, first post-reset contended grant to R0.
REQ-031 R1 store 0x40=0x1234 cycle N, R0 load 0x40 cycle N+1 -> R0 rdata=0x1234 at N+2, r1_rvalid only at N+1.
